// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
endpackage

// File: rtl/sync_fifo_rr_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after base.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic         found,
    output logic [W-1:0] idx
);
    always_comb begin
        int c;
        logic [W-1:0] ci;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(base) + i;
            if (c >= N) c = c - N;
            ci = W'(c);
            if (!found && req[ci]) begin
                found = 1'b1;
                idx   = ci;
            end
        end
    end
endmodule

// File: rtl/sync_fifo_rr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ
// producers, with a registered output stage tagged by source index.
module sync_fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int LB_NUM_REQ = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          clear,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [LB_NUM_REQ-1:0]         out_id,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          grant_valid,
    output logic [LB_NUM_REQ-1:0]         grant_id
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [LB_NUM_REQ-1:0] LAST_ID = LB_NUM_REQ'(NUM_REQ - 1);

    arb_state_t              state;
    logic [LB_NUM_REQ-1:0]   owner;
    logic [LB_NUM_REQ-1:0]   rr_ptr;
    logic [LB_NUM_REQ-1:0]   next_ptr;
    logic [CW-1:0]           beat_cnt;
    logic                    pick_found;
    logic [LB_NUM_REQ-1:0]   pick_idx;
    logic                    can_load;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   owner_data;

    rr_picker #(.N(NUM_REQ), .W(LB_NUM_REQ)) u_picker (
        .req   (in_valid),
        .base  (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign can_load    = !out_valid || out_ready;
    assign xfer        = (state == GRANT) && in_valid[owner] && can_load;
    assign owner_data  = in_data[owner*DATA_WIDTH +: DATA_WIDTH];
    assign next_ptr    = (owner == LAST_ID) ? '0 : owner + 1'b1;
    assign grant_valid = (state == GRANT);
    assign grant_id    = owner;

    always_comb begin
        in_ready = '0;
        if (state == GRANT) in_ready[owner] = can_load;
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= owner_data;
                out_id    <= owner;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // stall cycles leave beat_cnt and owner untouched
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end else if (!in_valid[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sync_fifo_rr_arbiter.sv
// Randomized bench: transaction-level arbiter model plus beat scoreboard.
module tb_sync_fifo_rr_arbiter;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int LB = $clog2(N);

    logic            clk = 1'b0;
    logic            rstn;
    logic            clear;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic [LB-1:0]   out_id;
    logic            out_valid;
    logic            out_ready;
    logic            grant_valid;
    logic [LB-1:0]   grant_id;

    sync_fifo_rr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .LB_NUM_REQ(LB)
    ) dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_id(out_id), .out_valid(out_valid),
        .out_ready(out_ready), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LB-1:0] id;
        logic [DW-1:0] d;
    } beat_t;

    beat_t    exp_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;

    // abstract model: who holds the port, how many beats taken, where the
    // rotation resumes, and what sits in the output register
    bit       m_gnt;
    int       m_owner;
    int       m_ptr;
    int       m_cnt;
    bit       m_ov;
    logic [DW-1:0] m_od;
    int       m_oid;

    bit       pend[N];
    int       seq[N];
    logic [DW-1:0] pdata[N];
    bit       gen_en;
    bit       random_ctl;
    int       stall;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_gnt = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_ov = 0; m_od = '0; m_oid = 0;
    endtask

    task automatic drive();
        if (random_ctl) begin
            rstn  = ($urandom_range(0, 299) != 0);
            clear = ($urandom_range(0, 149) == 0);
            if (stall == 0 && $urandom_range(0, 49) == 0) stall = 5;
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end else begin
            rstn = 1'b1; clear = 1'b0; out_ready = 1'b1;
        end
        for (int r = 0; r < N; r++) begin
            if (!pend[r] && gen_en && $urandom_range(0, 3) != 0) begin
                pend[r]  = 1;
                pdata[r] = DW'(r * 64 + seq[r] % 64);
                seq[r]++;
            end
            in_valid[r]          = pend[r];
            in_data[r*DW +: DW]  = pdata[r];
        end
    endtask

    task automatic check_and_advance();
        logic [N-1:0] exp_rdy;
        bit rdy_ok;
        bit acc;
        rdy_ok  = !m_ov || out_ready;
        exp_rdy = '0;
        if (m_gnt && rdy_ok) exp_rdy[m_owner] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("grant_valid", 32'(grant_valid), 32'(m_gnt));
        if (m_gnt) check("grant_id", 32'(grant_id), m_owner);
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check("out_data", 32'(out_data), 32'(m_od));
            check("out_id", 32'(out_id), m_oid);
        end
        acc = m_gnt && in_valid[m_owner] && rdy_ok;
        if (acc) pend[m_owner] = 0;
        if (!rstn || clear) begin
            if (m_ov && !out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
            model_reset();
        end else begin
            if (acc) begin
                exp_q.push_back('{id: LB'(m_owner), d: pdata[m_owner]});
                m_ov = 1; m_od = pdata[m_owner]; m_oid = m_owner;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (!m_gnt) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_gnt && in_valid[(m_ptr + k) % N]) begin
                        m_gnt = 1; m_owner = (m_ptr + k) % N; m_cnt = 0;
                    end
                end
            end else if (acc) begin
                m_cnt++;
                if (m_cnt == MB) begin
                    m_gnt = 0; m_ptr = (m_owner + 1) % N;
                end
            end else if (!in_valid[m_owner]) begin
                m_gnt = 0; m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_and_advance();
    endtask

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard: unexpected beat id %0d data %0h at %0t",
                             out_id, out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_id", 32'(out_id), 32'(e.id));
                    check("beat_data", 32'(out_data), 32'(e.d));
                end
            end
        end
    end

    initial begin : stim
        rstn = 1'b0; clear = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_data = '0;
        gen_en = 0; random_ctl = 0; stall = 0;
        for (int r = 0; r < N; r++) begin
            pend[r] = 0; seq[r] = 0; pdata[r] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        gen_en = 1;
        repeat (200) step();
        random_ctl = 1;
        repeat (4000) step();
        random_ctl = 0;
        gen_en = 0;
        repeat (60) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(grant_valid), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
